timer_alarm: RTL and testbench
==============================

TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 The parameter WIDTH SHALL have default 16 and set the width of Time, the registers and the data buses.
REQ-002 Clock  input  1  is the single system clock; all state changes SHALL occur on its rising edge.
REQ-003 Reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 Time  input  WIDTH  SHALL be the free-running system time base, incrementing by 1 per tick and wrapping at 2^WIDTH.
REQ-005 WrEn  input  1  SHALL be the register write strobe, sampled each cycle.
REQ-006 WrAddr  input  2  SHALL select the write target: 0=CTRL, 1=INTERVAL, 3=STATUS; writes to 2 SHALL be ignored.
REQ-007 WrData  input  WIDTH  SHALL carry the write data.
REQ-008 RdAddr  input  2  SHALL select the read source: 0=CTRL, 1=INTERVAL, 2=DEADLINE, 3=STATUS.
REQ-009 RdData  output  WIDTH  SHALL be registered read data, valid 1 cycle after RdAddr is presented.
REQ-010 IrqAck  input  1  SHALL be a single-cycle interrupt acknowledge.
REQ-011 Irq  output  1  SHALL be a registered, level interrupt equal to STATUS.Pending.

Function
REQ-012 The register fields SHALL be: CTRL bit0=Enable, bit1=Periodic, other bits read 0; STATUS bit0=Pending, bit1=Overrun, other bits read 0.
REQ-013 The block SHALL register Time into TimePrev every cycle; a tick SHALL be defined as Time != TimePrev.
REQ-014 The FSM SHALL have states IDLE and ARMED; CTRL.Enable SHALL read 1 exactly while in ARMED.
REQ-015 IDLE->ARMED SHALL occur on a CTRL write with WrData bit0=1 while INTERVAL != 0, with DEADLINE <= Time + INTERVAL mod 2^WIDTH in the same cycle.
REQ-016 A CTRL write with bit0=1 while INTERVAL==0 SHALL be ignored: state stays IDLE and DEADLINE is unchanged.
REQ-017 A CTRL write with bit0=0 SHALL force IDLE without changing Pending or Overrun; Periodic SHALL always take WrData bit1.
REQ-018 An INTERVAL write while ARMED SHALL store the value and re-arm with DEADLINE <= Time + WrData; if WrData==0, the FSM SHALL go to IDLE.
REQ-019 A match SHALL be ARMED AND tick AND Time==DEADLINE; a Time equal to DEADLINE without a tick SHALL NOT match.
REQ-020 On a match, Pending SHALL be set on the next edge, so Irq rises 1 cycle after the matching Time value first appears.
REQ-021 On a match with Pending already 1, the block SHALL set Overrun to 1.
REQ-022 On a match in periodic mode, DEADLINE SHALL be set to DEADLINE + INTERVAL mod 2^WIDTH (drift-free) and the FSM SHALL stay ARMED.
REQ-023 On a match in one-shot mode, the FSM SHALL go to IDLE and DEADLINE SHALL hold.
REQ-024 IrqAck SHALL clear Pending on the next edge.
REQ-025 A match and IrqAck in the same cycle SHALL leave Pending=1 and Overrun unchanged.
REQ-026 A STATUS write SHALL be write-1-to-clear on bit0 and bit1; a new event in the same cycle SHALL win.
REQ-027 A register write and a match in the same cycle SHALL be resolved with the write taking priority over the DEADLINE update, and the match SHALL still set Pending.
REQ-028 Deadline arithmetic SHALL wrap modulo 2^WIDTH; for example, Time=0xFFF0 with INTERVAL=0x0020 SHALL give DEADLINE=0x0010.

Reset
REQ-029 While Reset=0, the block SHALL force state=IDLE, Periodic=0, INTERVAL=0, DEADLINE=0, Pending=0, Overrun=0, TimePrev=0, RdData=0 and Irq=0, regardless of Clock.
REQ-030 A Reset assertion mid-operation SHALL abort any armed deadline, and no Irq SHALL occur after release until the block is re-armed.

Verification
REQ-031 One-shot: INTERVAL=5, CTRL=0x1 at Time=0x0100 -> DEADLINE=0x0105, Irq=1 one cycle after Time becomes 0x0105, CTRL reads 0x0.
REQ-032 Periodic with ack: INTERVAL=3, CTRL=0x3 at Time=0x0010 -> Irq at Time 0x13, 0x16 and 0x19, each cleared by IrqAck, Overrun stays 0.
REQ-033 Overrun: periodic INTERVAL=2 with no ack -> second match sets STATUS=0x3; a STATUS write of 0x2 -> STATUS=0x1; IrqAck -> STATUS=0x0.
REQ-034 Wrap and zero: Time=0xFFFE, INTERVAL=4, arm -> match at Time 0x0002; INTERVAL=0, arm -> stays IDLE, no Irq.
REQ-035 Simultaneous and reset: IrqAck in the same cycle as a match -> Pending stays 1; Reset pulsed low while ARMED and asynchronous to Clock -> all registers 0 immediately, no Irq afterwards.

Source files
------------

// File: rtl/timer_alarm_if.sv
// Register-bus and interrupt bundle for timer_alarm: time base, write/read ports,
// interrupt acknowledge and the level interrupt.
interface timer_alarm_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] Time;
   logic             WrEn;
   logic [1:0]       WrAddr;
   logic [WIDTH-1:0] WrData;
   logic [1:0]       RdAddr;
   logic [WIDTH-1:0] RdData;
   logic             IrqAck;
   logic             Irq;

   modport master (
      output Time, WrEn, WrAddr, WrData, RdAddr, IrqAck,
      input  RdData, Irq
   );

   modport slave (
      input  Time, WrEn, WrAddr, WrData, RdAddr, IrqAck,
      output RdData, Irq
   );
endinterface

// File: rtl/timer_alarm.sv
// Deadline alarm against a free-running time base: one-shot or drift-free periodic
// matches raise a level interrupt with pending/overrun status.
module timer_alarm #(
   parameter int WIDTH = 16
) (
   input logic         Clock,
   input logic         Reset,
   timer_alarm_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

   localparam logic [1:0]       ADDR_CTRL     = 2'd0;
   localparam logic [1:0]       ADDR_INTERVAL = 2'd1;
   localparam logic [1:0]       ADDR_DEADLINE = 2'd2;
   localparam logic [1:0]       ADDR_STATUS   = 2'd3;
   localparam logic [WIDTH-1:0] ZERO          = {WIDTH{1'b0}};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] time_prev_r;
   logic [WIDTH-1:0] interval_r;
   logic [WIDTH-1:0] deadline_r;
   logic [WIDTH-1:0] deadline_nxt_s;
   logic [WIDTH-1:0] rd_data_r;
   logic [WIDTH-1:0] rd_mux_s;
   logic             periodic_r;
   logic             pending_r;
   logic             overrun_r;
   logic             irq_r;
   logic             enable_s;
   logic             tick_s;
   logic             match_s;
   logic             ctrl_wr_s;
   logic             intv_wr_s;
   logic             stat_wr_s;
   logic             arm_s;
   logic             rearm_s;
   logic             pending_nxt_s;
   logic             overrun_nxt_s;

   // Write decode, tick detection and deadline match
   always_comb begin
      tick_s    = (bus.Time != time_prev_r);
      ctrl_wr_s = bus.WrEn && (bus.WrAddr == ADDR_CTRL);
      intv_wr_s = bus.WrEn && (bus.WrAddr == ADDR_INTERVAL);
      stat_wr_s = bus.WrEn && (bus.WrAddr == ADDR_STATUS);
      arm_s     = (state_r == IDLE) && ctrl_wr_s && bus.WrData[0] && (interval_r != ZERO);
      rearm_s   = (state_r == ARMED) && intv_wr_s && (bus.WrData != ZERO);
      match_s   = (state_r == ARMED) && tick_s && (bus.Time == deadline_r);
   end

   // FSM state register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; register writes outrank a coincident match
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (arm_s) begin
               state_nxt_s = ARMED;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ARMED: begin
            if (ctrl_wr_s && !bus.WrData[0]) begin
               state_nxt_s = IDLE;
            end else if (intv_wr_s && (bus.WrData == ZERO)) begin
               state_nxt_s = IDLE;
            end else if (rearm_s) begin
               state_nxt_s = ARMED;
            end else if (match_s && !periodic_r) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = ARMED;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      enable_s = (state_r == ARMED);
   end

   // Next deadline and status flags; periodic reload adds to the old deadline so no drift accrues
   always_comb begin
      if (arm_s) begin
         deadline_nxt_s = bus.Time + interval_r;
      end else if (rearm_s) begin
         deadline_nxt_s = bus.Time + bus.WrData;
      end else if (match_s && periodic_r && (state_nxt_s == ARMED)) begin
         deadline_nxt_s = deadline_r + interval_r;
      end else begin
         deadline_nxt_s = deadline_r;
      end
      pending_nxt_s = match_s | (pending_r & ~bus.IrqAck & ~(stat_wr_s & bus.WrData[0]));
      overrun_nxt_s = (match_s & pending_r & ~bus.IrqAck)
                    | (overrun_r & ~(stat_wr_s & bus.WrData[1]));
   end

   // Read-data source select
   always_comb begin
      case (bus.RdAddr)
         ADDR_CTRL:     rd_mux_s = {{(WIDTH-2){1'b0}}, periodic_r, enable_s};
         ADDR_INTERVAL: rd_mux_s = interval_r;
         ADDR_DEADLINE: rd_mux_s = deadline_r;
         ADDR_STATUS:   rd_mux_s = {{(WIDTH-2){1'b0}}, overrun_r, pending_r};
         default:       rd_mux_s = ZERO;
      endcase
   end

   // Datapath registers, status, and registered bus outputs
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         time_prev_r <= ZERO;
         interval_r  <= ZERO;
         deadline_r  <= ZERO;
         periodic_r  <= 1'b0;
         pending_r   <= 1'b0;
         overrun_r   <= 1'b0;
         rd_data_r   <= ZERO;
         irq_r       <= 1'b0;
      end else begin
         time_prev_r <= bus.Time;
         deadline_r  <= deadline_nxt_s;
         pending_r   <= pending_nxt_s;
         overrun_r   <= overrun_nxt_s;
         rd_data_r   <= rd_mux_s;
         irq_r       <= pending_nxt_s;
         if (intv_wr_s) begin
            interval_r <= bus.WrData;
         end
         if (ctrl_wr_s) begin
            periodic_r <= bus.WrData[1];
         end
      end
   end

   assign bus.RdData = rd_data_r;
   assign bus.Irq    = irq_r;
endmodule

// File: tb/tb_timer_alarm.sv
// Self-checking bench for timer_alarm: vector table for the one-shot case plus
// hand-written periodic, overrun, wrap, zero-interval, ack-collision and reset sequences.
module tb_timer_alarm;
   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_INTV = 2'd1;
   localparam logic [1:0] A_DL   = 2'd2;
   localparam logic [1:0] A_STAT = 2'd3;

   typedef struct {
      logic [15:0] t;
      logic        we;
      logic [1:0]  wa;
      logic [15:0] wd;
      logic [1:0]  ra;
      logic        ack;
      logic [15:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] exp;
   } sb_t;

   logic Clock;
   logic Reset;
   int   checks;
   int   errors;
   sb_t  sb_q[$];
   vec_t vt[11];

   timer_alarm_if #(.WIDTH(16)) bus ();
   timer_alarm #(.WIDTH(16)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, optionally queue a read expectation, compare after the edge
   task automatic cyc(input logic [15:0] t, input logic we, input logic [1:0] wa,
                      input logic [15:0] wd, input logic [1:0] ra, input logic ack,
                      input logic chk, input logic [15:0] exp_rd, input logic exp_irq,
                      input string name);
      sb_t e;
      bus.Time   = t;
      bus.WrEn   = we;
      bus.WrAddr = wa;
      bus.WrData = wd;
      bus.RdAddr = ra;
      bus.IrqAck = ack;
      if (chk) begin
         e.name = {name, "_rd"};
         e.exp  = exp_rd;
         sb_q.push_back(e);
      end
      @(posedge Clock);
      #1;
      check({name, "_irq"}, {15'd0, bus.Irq}, {15'd0, exp_irq});
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.name, bus.RdData, e.exp);
      end
      bus.WrEn   = 1'b0;
      bus.IrqAck = 1'b0;
   endtask

   task automatic idle(input logic [15:0] t, input logic exp_irq, input string name);
      cyc(t, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0000, exp_irq, name);
   endtask

   task automatic wr(input logic [15:0] t, input logic [1:0] wa, input logic [15:0] wd,
                     input logic exp_irq, input string name);
      cyc(t, 1'b1, wa, wd, 2'd0, 1'b0, 1'b0, 16'h0000, exp_irq, name);
   endtask

   task automatic rd(input logic [15:0] t, input logic [1:0] ra, input logic [15:0] exp,
                     input logic exp_irq, input string name);
      cyc(t, 1'b0, 2'd0, 16'h0000, ra, 1'b0, 1'b1, exp, exp_irq, name);
   endtask

   task automatic ack(input logic [15:0] t, input logic exp_irq, input string name);
      cyc(t, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0000, exp_irq, name);
   endtask

   initial begin
      logic [15:0] tw;
      checks = 0;
      errors = 0;

      // One-shot: INTERVAL=5, arm at 0x0100, deadline 0x0105
      vt[0]  = '{16'h0100, 1'b1, A_INTV, 16'h0005, A_STAT, 1'b0, 16'h0000, 1'b0};
      vt[1]  = '{16'h0100, 1'b1, A_CTRL, 16'h0001, A_INTV, 1'b0, 16'h0005, 1'b0};
      vt[2]  = '{16'h0101, 1'b0, A_CTRL, 16'h0000, A_DL,   1'b0, 16'h0105, 1'b0};
      vt[3]  = '{16'h0102, 1'b0, A_CTRL, 16'h0000, A_CTRL, 1'b0, 16'h0001, 1'b0};
      vt[4]  = '{16'h0103, 1'b0, A_CTRL, 16'h0000, A_STAT, 1'b0, 16'h0000, 1'b0};
      vt[5]  = '{16'h0104, 1'b0, A_CTRL, 16'h0000, A_CTRL, 1'b0, 16'h0001, 1'b0};
      vt[6]  = '{16'h0105, 1'b0, A_CTRL, 16'h0000, A_STAT, 1'b0, 16'h0000, 1'b1};
      vt[7]  = '{16'h0106, 1'b0, A_CTRL, 16'h0000, A_CTRL, 1'b0, 16'h0000, 1'b1};
      vt[8]  = '{16'h0107, 1'b0, A_CTRL, 16'h0000, A_STAT, 1'b0, 16'h0001, 1'b1};
      vt[9]  = '{16'h0107, 1'b0, A_CTRL, 16'h0000, A_DL,   1'b1, 16'h0105, 1'b0};
      vt[10] = '{16'h0108, 1'b0, A_CTRL, 16'h0000, A_STAT, 1'b0, 16'h0000, 1'b0};

      Reset      = 1'b0;
      bus.Time   = 16'h00FF;
      bus.WrEn   = 1'b0;
      bus.WrAddr = 2'd0;
      bus.WrData = 16'h0000;
      bus.RdAddr = 2'd0;
      bus.IrqAck = 1'b0;
      #2;
      check("reset_irq", {15'd0, bus.Irq}, 16'h0000);
      check("reset_rddata", bus.RdData, 16'h0000);
      #20;
      Reset = 1'b1;
      @(posedge Clock);
      #1;

      for (int i = 0; i < 11; i++) begin
         cyc(vt[i].t, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ra, vt[i].ack, 1'b1,
             vt[i].exp_rd, vt[i].exp_irq, $sformatf("oneshot_v%0d", i));
      end

      // Periodic INTERVAL=3 armed at 0x10: matches at 0x13, 0x16, 0x19, each acked
      wr(16'h000F, A_INTV, 16'h0003, 1'b0, "per_intv");
      wr(16'h0010, A_CTRL, 16'h0003, 1'b0, "per_arm");
      rd(16'h0011, A_CTRL, 16'h0003, 1'b0, "per_ctrl");
      idle(16'h0012, 1'b0, "per_12");
      idle(16'h0013, 1'b1, "per_m1");
      ack(16'h0014, 1'b0, "per_ack1");
      idle(16'h0015, 1'b0, "per_15");
      idle(16'h0016, 1'b1, "per_m2");
      ack(16'h0017, 1'b0, "per_ack2");
      rd(16'h0018, A_DL, 16'h0019, 1'b0, "per_dl");
      idle(16'h0019, 1'b1, "per_m3");
      ack(16'h001A, 1'b0, "per_ack3");
      cyc(16'h001B, 1'b1, A_CTRL, 16'h0000, A_STAT, 1'b0, 1'b1, 16'h0000, 1'b0, "per_stop");

      // Overrun: periodic INTERVAL=2, no ack across two matches
      wr(16'h0020, A_INTV, 16'h0002, 1'b0, "ovr_intv");
      wr(16'h0020, A_CTRL, 16'h0003, 1'b0, "ovr_arm");
      idle(16'h0021, 1'b0, "ovr_21");
      idle(16'h0022, 1'b1, "ovr_m1");
      idle(16'h0023, 1'b1, "ovr_23");
      idle(16'h0024, 1'b1, "ovr_m2");
      cyc(16'h0025, 1'b1, A_CTRL, 16'h0000, A_STAT, 1'b0, 1'b1, 16'h0003, 1'b1, "ovr_stop");
      cyc(16'h0025, 1'b1, A_STAT, 16'h0002, A_STAT, 1'b0, 1'b1, 16'h0003, 1'b1, "ovr_w1c");
      rd(16'h0025, A_STAT, 16'h0001, 1'b1, "ovr_after_w1c");
      cyc(16'h0025, 1'b0, 2'd0, 16'h0000, A_STAT, 1'b1, 1'b1, 16'h0001, 1'b0, "ovr_ack");
      rd(16'h0025, A_STAT, 16'h0000, 1'b0, "ovr_clear");

      // Deadline wrap: arm at 0xFFFE with INTERVAL=4 -> match at 0x0002
      wr(16'hFFFD, A_INTV, 16'h0004, 1'b0, "wrap_intv");
      wr(16'hFFFE, A_CTRL, 16'h0001, 1'b0, "wrap_arm");
      rd(16'hFFFF, A_DL, 16'h0002, 1'b0, "wrap_dl");
      idle(16'h0000, 1'b0, "wrap_0");
      idle(16'h0001, 1'b0, "wrap_1");
      idle(16'h0002, 1'b1, "wrap_m");
      ack(16'h0003, 1'b0, "wrap_ack");
      wr(16'hFFF0, A_INTV, 16'h0020, 1'b0, "wrap2_intv");
      wr(16'hFFF0, A_CTRL, 16'h0001, 1'b0, "wrap2_arm");
      rd(16'hFFF0, A_DL, 16'h0010, 1'b0, "wrap2_dl");
      wr(16'hFFF0, A_CTRL, 16'h0000, 1'b0, "wrap2_stop");

      // Zero interval: arming is ignored, deadline untouched, no interrupt
      wr(16'hFFF0, A_INTV, 16'h0000, 1'b0, "zero_intv");
      wr(16'hFFF0, A_CTRL, 16'h0001, 1'b0, "zero_arm");
      rd(16'hFFF1, A_CTRL, 16'h0000, 1'b0, "zero_ctrl");
      tw = 16'hFFF2;
      for (int i = 0; i < 33; i++) begin
         idle(tw, 1'b0, $sformatf("zero_t%0d", i));
         tw = tw + 16'h0001;
      end
      rd(tw, A_DL, 16'h0010, 1'b0, "zero_dl");
      rd(tw, A_STAT, 16'h0000, 1'b0, "zero_stat");

      // Ack in the same cycle as a match keeps Pending; no overrun from that collision
      wr(16'h0050, A_INTV, 16'h0002, 1'b0, "sim_intv");
      wr(16'h0050, A_CTRL, 16'h0001, 1'b0, "sim_arm");
      idle(16'h0051, 1'b0, "sim_51");
      ack(16'h0052, 1'b1, "sim_m1_ack");
      rd(16'h0053, A_STAT, 16'h0001, 1'b1, "sim_stat1");
      wr(16'h0053, A_CTRL, 16'h0003, 1'b1, "sim_rearm");
      idle(16'h0054, 1'b1, "sim_54");
      ack(16'h0055, 1'b1, "sim_m2_ack");
      rd(16'h0056, A_STAT, 16'h0001, 1'b1, "sim_stat2");

      // Asynchronous reset mid-cycle while armed
      #3;
      Reset = 1'b0;
      #1;
      check("async_rst_irq", {15'd0, bus.Irq}, 16'h0000);
      check("async_rst_rddata", bus.RdData, 16'h0000);
      repeat (2) @(posedge Clock);
      #4;
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      rd(16'h0057, A_CTRL, 16'h0000, 1'b0, "post_rst_ctrl");
      rd(16'h0058, A_INTV, 16'h0000, 1'b0, "post_rst_intv");
      rd(16'h0059, A_DL, 16'h0000, 1'b0, "post_rst_dl");
      rd(16'h005A, A_STAT, 16'h0000, 1'b0, "post_rst_stat");
      idle(16'h005B, 1'b0, "post_rst_5b");
      idle(16'h005C, 1'b0, "post_rst_5c");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
